// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// The TRAP state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_LUI
`ifdef MC_ILLEGAL_TRAP_EN
      ,
      S_TRAP
`endif
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_U = 3'b010;
   localparam logic [2:0] IMM_B = 3'b101;
   localparam logic [2:0] IMM_J = 3'b110;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/imm_src_dec.sv
// Opcode to immediate-format decode, plus a flag marking opcodes this
// controller knows how to sequence.
module imm_src_dec
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] Op,
   output logic [2:0] ImmSrc,
   output logic       op_legal
);

   // Pure lookup on the opcode; anything unrecognised is I-format and illegal.
   always_comb begin
      ImmSrc   = IMM_I;
      op_legal = 1'b1;
      case (Op)
         OP_LOAD:   ImmSrc = IMM_I;
         OP_STORE:  ImmSrc = IMM_S;
         OP_RTYPE:  ImmSrc = IMM_I;
         OP_ITYPE:  ImmSrc = IMM_I;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         OP_LUI:    ImmSrc = IMM_U;
         default: begin
            ImmSrc   = IMM_I;
            op_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core.
// Optional feature: MC_ILLEGAL_TRAP_EN adds a TRAP state and the Illegal port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC; waits on MemReady
// DECODE   | read registers, OldPC+imm -> ALUOut (branch/jump target)
// MEMADR   | rs1+imm -> ALUOut (load/store address)
// MEMREAD  | read data memory at ALUOut; waits on MemReady
// MEMWB    | MemData -> rd
// MEMWRITE | write data memory at ALUOut; waits on MemReady
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | ALUOut -> rd
// BRANCH   | rs1-rs2, PC <- ALUOut when the condition holds
// JAL      | OldPC+4 -> ALUOut, PC <- target
// LUI      | 0+imm -> ALUOut
// TRAP     | illegal opcode seen; parked until reset (macro only)
module multicycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic [2:0] Funct3,
   input  logic       Funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc
`ifdef MC_ILLEGAL_TRAP_EN
   ,
   output logic       Illegal
`endif
);

   state_t state;
   state_t state_n;
   logic   op_legal;

   // Funct7b5 and the upper Funct3 bits belong to the ALU decoder, not here.
   logic unused_funct_bits;
   assign unused_funct_bits = ^{Funct7b5, Funct3[2:1]};

   imm_src_dec u_imm_src_dec (
      .Op       (Op),
      .ImmSrc   (ImmSrc),
      .op_legal (op_legal)
   );

   // State register with synchronous reset back to FETCH.
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_n;
   end

   // Next-state and Moore outputs; only FETCH handshake and BRANCH look at inputs.
   always_comb begin
      state_n   = state;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ALUOp     = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            AdrSrc    = 1'b0;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALUOP_ADD;
            ResultSrc = RES_ALURESULT;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
            if (MemReady) state_n = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
            if (!op_legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
               state_n = S_TRAP;
`else
               state_n = S_FETCH;
`endif
            end else begin
               case (Op)
                  OP_LOAD,
                  OP_STORE:  state_n = S_MEMADR;
                  OP_RTYPE:  state_n = S_EXECR;
                  OP_ITYPE:  state_n = S_EXECI;
                  OP_BRANCH: state_n = S_BRANCH;
                  OP_JAL:    state_n = S_JAL;
                  OP_LUI:    state_n = S_LUI;
                  default:   state_n = S_FETCH;
               endcase
            end
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
            state_n = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) state_n = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_MEMDATA;
            RegWrite  = 1'b1;
            state_n   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (MemReady) state_n = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_FUNCT;
            state_n = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
            state_n = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
            state_n   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_RS2;
            ALUOp     = ALUOP_SUB;
            ResultSrc = RES_ALUOUT;
            // Funct3[0] distinguishes bne from beq.
            PCWrite   = Zero ^ Funct3[0];
            state_n   = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALUOP_ADD;
            ResultSrc = RES_ALUOUT;
            PCWrite   = 1'b1;
            state_n   = S_ALUWB;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
            state_n = S_ALUWB;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: begin
            state_n = S_TRAP;
         end
`endif
         default: begin
            state_n = S_FETCH;
         end
      endcase
   end

`ifdef MC_ILLEGAL_TRAP_EN
   // Illegal is a plain decode of the parked state.
   always_comb begin
      Illegal = (state == S_TRAP);
   end
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the RV32I core. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, and selects the immediate format for the immediate generator (`ImmSrc`). It also drives all mux selects and write enables for the shared ALU, memory and register file, and stalls on a memory-ready handshake. It sits between the instruction register and the datapath.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Op`  in  7  opcode, `Instr[6:0]`.
- `Funct3`  in  3  `Instr[14:12]`.
- `Funct7b5`  in  1  `Instr[30]`; passed to the ALU decoder through `ALUOp`, otherwise unused.
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0=PC, 1=ALUOut.
- `MemWrite`  out  1  data memory write strobe.
- `IRWrite`  out  1  instruction register and OldPC enable.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result select: 00=ALUOut, 01=MemData, 10=ALUResult.
- `ALUSrcA`  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero.
- `ALUSrcB`  out  2  ALU B select: 00=rs2, 01=ImmExt, 10=constant 4.
- `ALUOp`  out  2  ALU op: 00=add, 01=sub, 10=decode from funct fields.
- `ImmSrc`  out  3  immediate format: I=000, S=001, U=010, B=101, J=110.
- `Illegal`  out  1  illegal-opcode flag; exists only with `MC_ILLEGAL_TRAP_EN`.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, plus TRAP with the macro.
- Outputs not listed for a state are 0.
- FETCH: `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - `IRWrite`=`PCWrite`=`MemReady`.
  - Stays in FETCH while `MemReady`=0; goes to DECODE when `MemReady`=1.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (branch/jump target into ALUOut). Next state by `Op`:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other opcode -> FETCH (no architectural effect)
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: `AdrSrc`=1. Holds until `MemReady`, then goes to MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1. Goes to FETCH.
- MEMWRITE: `AdrSrc`=1, `MemWrite`=1. Holds until `MemReady`, then goes to FETCH.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Goes to ALUWB.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Goes to ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1. Goes to FETCH.
- BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00.
  - `PCWrite` = `Zero` XOR `Funct3[0]` (beq taken on Zero=1, bne taken on Zero=0).
  - Goes to FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCWrite`=1. Goes to ALUWB (writes PC+4 to rd).
- LUI: `ALUSrcA`=11, `ALUSrcB`=01, `ALUOp`=00. Goes to ALUWB.
- `ImmSrc` is combinational from `Op` in every state:
  - load and 0010011 -> 000
  - store -> 001
  - branch -> 101
  - lui -> 010
  - jal -> 110
  - all other opcodes -> 000

## Timing
- Reset: state=FETCH on the next edge; outputs take FETCH values; `Illegal`=0.
- Reset has priority in any state, including a MEMREAD or MEMWRITE waiting on `MemReady`.
- Cycle counts with `MemReady` held at 1:
  - lw 5
  - sw 4
  - R-type, I-ALU, jal, lui 4
  - branch 3
  - undefined opcode 2
- Each cycle with `MemReady`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- While waiting, all outputs hold their state values and `MemWrite` stays asserted.
- `PCWrite` in BRANCH is the only output that depends on inputs other than `Op`/`MemReady`; it is valid in the same cycle.

## Configuration
- Macro: `MC_ILLEGAL_TRAP_EN`.
- Defined:
  - An undefined opcode in DECODE goes to TRAP.
  - TRAP asserts `Illegal`=1 with all enables 0, and is left only by `rst`.
- Undefined: no TRAP state and no `Illegal` port; an undefined opcode returns to FETCH.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum
  - opcode constants
  - `ImmSrc` encodings
  - `ALUSrcA`/`ALUSrcB`/`ResultSrc` encodings
- Sub-module `imm_src_dec`: combinational `Op` -> `ImmSrc` plus an opcode-legal flag. The legal flag feeds the DECODE transition.

## Test plan
- lw (`Op`=0000011), `MemReady`=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; `RegWrite`=1 only in cycle 5 with `ResultSrc`=01; `ImmSrc`=000.
- sw (`Op`=0100011), `MemReady`=0 for 2 cycles in MEMWRITE -> `MemWrite`=1 for exactly 3 cycles, `AdrSrc`=1; FETCH on cycle 7; `ImmSrc`=001.
- beq (`Funct3`=000) with `Zero`=1 -> `PCWrite`=1 in cycle 3, `ImmSrc`=101; repeat with `Zero`=0 -> `PCWrite`=0; bne (`Funct3`=001) with `Zero`=0 -> `PCWrite`=1.
- `MemReady`=0 for 3 cycles in FETCH -> `IRWrite`=`PCWrite`=0 and state held; both pulse 1 on the 4th cycle, then DECODE.
- `rst`=1 while waiting in MEMREAD -> next cycle FETCH outputs (`ALUSrcB`=10, `ResultSrc`=10, `AdrSrc`=0), no `RegWrite`.
- `Op`=0000000 -> without the macro, DECODE then FETCH with no enables asserted; with `MC_ILLEGAL_TRAP_EN`, `Illegal`=1 held until `rst`.
